// File: rtl/leaf_inject_arbiter_pkg.sv
// Shared types and helpers for the leaf injection arbiter.
package leaf_inject_arbiter_pkg;

  // Widest requester vector the round-robin helper can search.
  localparam int unsigned RR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    BACKOFF
  } state_t;

  // Round-robin winner: first set bit of vec strictly after 'last', wrapping
  // within n entries. Returns 'last' when vec is empty (caller masks that).
  // The search runs from the farthest offset down so the nearest hit wins.
  function automatic int unsigned rr_next(input logic [RR_MAX-1:0] vec,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned win;
    logic [4:0]  pos;
    win = last;
    for (int unsigned k = RR_MAX; k >= 1; k--) begin
      pos = 5'((last + k) % n);
      if (k <= n && vec[pos]) win = 32'(pos);
    end
    return win;
  endfunction

endpackage

// File: rtl/leaf_inject_arbiter_if.sv
// Requester handshake plus network leaf bus for one injection port.
interface leaf_inject_arbiter_if #(
  parameter int unsigned num_req = 4,
  parameter int unsigned p_sz    = 11
);
  logic [num_req-1:0]          req_valid;
  logic [num_req*(p_sz-1)-1:0] req_data;
  logic [num_req-1:0]          req_ready;
  logic [p_sz-1:0]             bus_o;
  logic                        resend;

  // Requesters and network side.
  modport master (output req_valid, req_data, resend, input req_ready, bus_o);
  // Arbiter side.
  modport slave  (input req_valid, req_data, resend, output req_ready, bus_o);
endinterface

// File: rtl/leaf_inject_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant plus winner index.
module rr_arbiter
  import leaf_inject_arbiter_pkg::*;
#(
  parameter int unsigned num_req = 4
) (
  input  logic [num_req-1:0]         req,
  input  logic [$clog2(num_req)-1:0] last_grant,
  output logic [num_req-1:0]         grant,
  output logic [$clog2(num_req)-1:0] idx
);
  localparam int unsigned IDX_W = $clog2(num_req);

  logic [RR_MAX-1:0] vec;
  int unsigned       win;

  // Search upward from last_grant+1; no grant when nobody requests.
  always_comb begin
    vec                = '0;
    vec[num_req-1:0]   = req;
    win                = rr_next(vec, 32'(last_grant), num_req);
    idx                = IDX_W'(win);
    grant              = '0;
    if (|req) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/leaf_inject_arbiter.sv
// Shares one BFT leaf injection port among num_req requesters, with
// round-robin grant, resend handling, optional backoff and starvation flag.
module leaf_inject_arbiter
  import leaf_inject_arbiter_pkg::*;
#(
  parameter int unsigned num_leaves = 8,
  parameter int unsigned payload_sz = 7,
  parameter int unsigned p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int unsigned num_req    = 4,
  parameter int unsigned backoff    = 2,
  parameter int unsigned max_retry  = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  leaf_inject_arbiter_if.slave         bus,
  output logic [$clog2(num_req)-1:0]   grant_idx,
  output logic                         busy,
  output logic                         err_starve,
  output logic [15:0]                  pkt_sent
);
  localparam int unsigned ADDR_W  = $clog2(num_leaves);
  localparam int unsigned D_W     = p_sz - 1;
  localparam int unsigned IDX_W   = $clog2(num_req);
  localparam int unsigned RETRY_W = $clog2(max_retry + 1);
  localparam int unsigned BO_W    = (backoff > 0) ? $clog2(backoff + 1) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]     dest;
    logic [payload_sz-1:0] payload;
  } pkt_t;

  state_t             state_q, state_n;
  logic [p_sz-1:0]    bus_q, bus_n;
  pkt_t               shadow_q, shadow_n;
  logic [IDX_W-1:0]   gidx_q, gidx_n;
  logic [IDX_W-1:0]   last_q, last_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic [BO_W-1:0]    bo_q, bo_n;
  logic [15:0]        sent_q, sent_n;
  logic               starve_q, starve_n;

  logic [num_req-1:0] grant_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [D_W-1:0]     win_data;
  logic               take;
  logic               hs;

  rr_arbiter #(.num_req(num_req)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .grant      (grant_oh),
    .idx        (win_idx)
  );

  assign win_data      = bus.req_data[win_idx*D_W +: D_W];
  assign hs            = take & (|grant_oh);
  assign bus.req_ready = take ? grant_oh : '0;
  assign bus.bus_o     = bus_q;
  assign grant_idx     = gidx_q;
  assign busy          = (state_q != IDLE);
  assign err_starve    = starve_q;
  assign pkt_sent      = sent_q;

  // Next-state logic; a handshake overrides the IDLE/accept path so a new
  // packet can follow an accepted one with no bubble.
  always_comb begin
    state_n  = state_q;
    bus_n    = bus_q;
    shadow_n = shadow_q;
    gidx_n   = gidx_q;
    last_n   = last_q;
    retry_n  = retry_q;
    bo_n     = bo_q;
    sent_n   = sent_q;
    starve_n = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: take = 1'b1;
      SEND: begin
        if (bus.resend) begin
          if (retry_q != RETRY_W'(max_retry)) begin
            retry_n  = retry_q + 1'b1;
            starve_n = (retry_q == RETRY_W'(max_retry - 1));
          end
          if (backoff != 0) begin
            bus_n   = '0;
            bo_n    = BO_W'(backoff);
            state_n = BACKOFF;
          end
        end else begin
          take    = 1'b1;
          sent_n  = sent_q + 16'd1;
          bus_n   = '0;
          state_n = IDLE;
        end
      end
      BACKOFF: begin
        bo_n = bo_q - 1'b1;
        if (bo_q == BO_W'(1)) begin
          bus_n   = {1'b1, shadow_q};
          state_n = SEND;
        end
      end
      default: state_n = IDLE;
    endcase
    if (hs) begin
      bus_n    = {1'b1, win_data};
      shadow_n = pkt_t'(win_data);
      gidx_n   = win_idx;
      last_n   = win_idx;
      retry_n  = '0;
      state_n  = SEND;
    end
  end

  // State and datapath registers; reset discards any in-flight packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bus_q    <= '0;
      shadow_q <= '0;
      gidx_q   <= '0;
      last_q   <= IDX_W'(num_req - 1);
      retry_q  <= '0;
      bo_q     <= '0;
      sent_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      bus_q    <= bus_n;
      shadow_q <= shadow_n;
      gidx_q   <= gidx_n;
      last_q   <= last_n;
      retry_q  <= retry_n;
      bo_q     <= bo_n;
      sent_q   <= sent_n;
      starve_q <= starve_n;
    end
  end
endmodule

// File: tb/tb_leaf_inject_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the injection port.
module tb_leaf_inject_arbiter;
  localparam int NR = 4;
  localparam int PS = 11;
  localparam int BO = 2;
  localparam int MR = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  leaf_inject_arbiter_if #(.num_req(NR), .p_sz(PS)) ifa ();
  leaf_inject_arbiter_if #(.num_req(NR), .p_sz(PS)) ifb ();

  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b, starve_a, starve_b;
  logic [15:0] sent_a, sent_b;

  leaf_inject_arbiter #(.num_leaves(8), .payload_sz(7), .p_sz(PS), .num_req(NR),
                        .backoff(BO), .max_retry(MR)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .grant_idx(grant_a), .busy(busy_a),
    .err_starve(starve_a), .pkt_sent(sent_a));

  leaf_inject_arbiter #(.num_leaves(8), .payload_sz(7), .p_sz(PS), .num_req(NR),
                        .backoff(0), .max_retry(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .grant_idx(grant_b), .busy(busy_b),
    .err_starve(starve_b), .pkt_sent(sent_b));

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_ready, act_ready;

  // Model of dut_a: what is on the wire, how many idle gap cycles remain,
  // who was served last, and how many packets the network has taken.
  bit          m_onbus;
  logic [9:0]  m_pkt;
  int          m_gap, m_last, m_owner, m_retry;
  logic [15:0] m_sent;
  bit          m_starve;

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [10:0] model_bus();
    return m_onbus ? {1'b1, m_pkt} : 11'h0;
  endfunction

  task automatic model_reset();
    m_onbus = 0; m_pkt = '0; m_gap = 0; m_last = NR - 1; m_owner = 0;
    m_retry = 0; m_sent = '0; m_starve = 0;
  endtask

  // One clock of stimulus on dut_a; captures ready before the edge and
  // advances the model at the edge. Returns #1 after the edge.
  task automatic drive_cycle(input logic rst, input logic [3:0] v,
                             input logic [39:0] d, input logic rs);
    int w;
    @(negedge clk);
    reset = rst; ifa.req_valid = v; ifa.req_data = d; ifa.resend = rs;
    #1;
    w = rr_pick(v, m_last);
    if (m_gap > 0 || (m_onbus && rs) || w < 0) exp_ready = 4'b0;
    else exp_ready = 4'(1 << w);
    act_ready = ifa.req_ready;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_starve = 0;
      if (m_gap > 0) begin
        if (m_gap == 1) m_onbus = 1;
        m_gap--;
      end else if (m_onbus && rs) begin
        if (m_retry < MR) begin
          m_retry++;
          if (m_retry == MR) m_starve = 1;
        end
        if (BO > 0) begin m_onbus = 0; m_gap = BO; end
      end else begin
        if (m_onbus) begin m_sent++; m_onbus = 0; end
        if (w >= 0) begin
          m_onbus = 1; m_pkt = d[w*10 +: 10]; m_owner = w; m_last = w; m_retry = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 4'b0, '0, 1'b0);
      n_tests++; if (ifa.bus_o !== 11'h0) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", ifa.bus_o, 11'h0); end
      n_tests++; if (act_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected %b", act_ready, 4'b0); end
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
      n_tests++; if (sent_a !== 16'd0) begin n_fail++; $display("FAIL reset_sent: got %0d expected 0", sent_a); end
      n_tests++; if (grant_a !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_a); end
    end
    n_tests++; if (ifb.bus_o !== 11'h0 || sent_b !== 16'd0) begin n_fail++; $display("FAIL reset_dut_b: got bus %h sent %0d expected 0 0", ifb.bus_o, sent_b); end
  endtask

  task automatic test_single();
    logic [39:0] d;
    d = '0; d[9:0] = 10'h25A;
    drive_cycle(1'b0, 4'b0001, d, 1'b0);
    n_tests++; if (act_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected %b", act_ready, 4'b0001); end
    n_tests++; if (ifa.bus_o !== 11'h65A) begin n_fail++; $display("FAIL single_bus: got %h expected %h", ifa.bus_o, 11'h65A); end
    n_tests++; if (sent_a !== 16'd0) begin n_fail++; $display("FAIL single_sent0: got %0d expected 0", sent_a); end
    drive_cycle(1'b0, 4'b0000, d, 1'b0);
    n_tests++; if (act_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_off: got %b expected 0000", act_ready); end
    n_tests++; if (ifa.bus_o !== 11'h0) begin n_fail++; $display("FAIL single_bus_off: got %h expected 000", ifa.bus_o); end
    n_tests++; if (sent_a !== 16'd1) begin n_fail++; $display("FAIL single_sent1: got %0d expected 1", sent_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_round_robin();
    logic [39:0] d;
    logic [9:0]  slot;
    int          e;
    d = {10'h3D3, 10'h2C2, 10'h1B1, 10'h0A0};
    drive_cycle(1'b1, 4'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 4'hF, d, 1'b0);
      e = k % 4;
      slot = d[e*10 +: 10];
      n_tests++; if (act_ready !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, act_ready, 4'(1 << e)); end
      n_tests++; if (ifa.bus_o !== {1'b1, slot}) begin n_fail++; $display("FAIL rr_bus[%0d]: got %h expected %h", k, ifa.bus_o, {1'b1, slot}); end
      n_tests++; if (grant_a !== 2'(e)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, grant_a, e); end
      n_tests++; if (sent_a !== 16'(k)) begin n_fail++; $display("FAIL rr_sent[%0d]: got %0d expected %0d", k, sent_a, k); end
    end
    drive_cycle(1'b0, 4'b0, d, 1'b0);
    n_tests++; if (ifa.bus_o !== 11'h0) begin n_fail++; $display("FAIL rr_bus_end: got %h expected 000", ifa.bus_o); end
    n_tests++; if (sent_a !== 16'd8) begin n_fail++; $display("FAIL rr_sent_end: got %0d expected 8", sent_a); end
  endtask

  task automatic test_resend_backoff();
    logic [39:0] d;
    logic [10:0] eb [6];
    logic [3:0]  er [6];
    logic [3:0]  vv [6];
    logic        rr [6];
    d = '0; d[9:0] = 10'h2AB; d[19:10] = 10'h111;
    vv = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    rr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    er = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    eb = '{11'h6AB, 11'h000, 11'h000, 11'h6AB, 11'h511, 11'h000};
    drive_cycle(1'b1, 4'b0, '0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, vv[c], d, rr[c]);
      n_tests++; if (act_ready !== er[c]) begin n_fail++; $display("FAIL bo_ready[%0d]: got %b expected %b", c, act_ready, er[c]); end
      n_tests++; if (ifa.bus_o !== eb[c]) begin n_fail++; $display("FAIL bo_bus[%0d]: got %h expected %h", c, ifa.bus_o, eb[c]); end
    end
    n_tests++; if (sent_a !== 16'd2) begin n_fail++; $display("FAIL bo_sent: got %0d expected 2", sent_a); end
  endtask

  task automatic test_starvation();
    ifa.req_valid = '0; ifa.resend = 1'b0;
    @(negedge clk);
    ifb.req_valid = 4'b0001; ifb.req_data = '0; ifb.req_data[9:0] = 10'h155; ifb.resend = 1'b0;
    #1;
    n_tests++; if (ifb.req_ready !== 4'b0001) begin n_fail++; $display("FAIL starve_ready0: got %b expected 0001", ifb.req_ready); end
    @(posedge clk); #1;
    n_tests++; if (ifb.bus_o !== 11'h555) begin n_fail++; $display("FAIL starve_bus0: got %h expected 555", ifb.bus_o); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ifb.req_valid = 4'b0010; ifb.resend = 1'b1;
      #1;
      n_tests++; if (ifb.req_ready !== 4'b0000) begin n_fail++; $display("FAIL starve_ready[%0d]: got %b expected 0000", k, ifb.req_ready); end
      @(posedge clk); #1;
      n_tests++; if (ifb.bus_o !== 11'h555) begin n_fail++; $display("FAIL starve_bus[%0d]: got %h expected 555", k, ifb.bus_o); end
      n_tests++; if (starve_b !== (k == 3)) begin n_fail++; $display("FAIL starve_pulse[%0d]: got %b expected %b", k, starve_b, k == 3); end
    end
    @(negedge clk);
    ifb.req_valid = 4'b0000; ifb.resend = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (sent_b !== 16'd1) begin n_fail++; $display("FAIL starve_sent: got %0d expected 1", sent_b); end
    n_tests++; if (ifb.bus_o !== 11'h0) begin n_fail++; $display("FAIL starve_bus_end: got %h expected 000", ifb.bus_o); end
  endtask

  task automatic test_reset_mid_backoff();
    logic [39:0] d;
    d = {10'h3EE, 10'h3C3, 10'h1DD, 10'h0F0};
    drive_cycle(1'b1, 4'b0, '0, 1'b0);
    drive_cycle(1'b0, 4'b0100, d, 1'b0);
    n_tests++; if (ifa.bus_o !== 11'h7C3) begin n_fail++; $display("FAIL rmb_load: got %h expected 7C3", ifa.bus_o); end
    drive_cycle(1'b0, 4'b0, d, 1'b1);
    drive_cycle(1'b0, 4'b0, d, 1'b0);
    drive_cycle(1'b1, 4'b0, d, 1'b0);
    n_tests++; if (ifa.bus_o !== 11'h0) begin n_fail++; $display("FAIL rmb_bus: got %h expected 000", ifa.bus_o); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmb_busy: got %b expected 0", busy_a); end
    drive_cycle(1'b0, 4'hF, d, 1'b0);
    n_tests++; if (act_ready !== 4'b0001) begin n_fail++; $display("FAIL rmb_ready: got %b expected 0001", act_ready); end
    n_tests++; if (ifa.bus_o !== 11'h4F0) begin n_fail++; $display("FAIL rmb_next: got %h expected 4F0", ifa.bus_o); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 4'b0, d, 1'b0);
      n_tests++; if (ifa.bus_o !== 11'h0) begin n_fail++; $display("FAIL rmb_idle[%0d]: got %h expected 000", i, ifa.bus_o); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  v;
    logic [39:0] d;
    logic        rs;
    drive_cycle(1'b1, 4'b0, '0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      v  = 4'($urandom());
      d  = 40'({$urandom(), $urandom()});
      rs = ((i % 200) >= 100 && (i % 200) < 160) ? 1'b1 : ($urandom_range(0, 3) == 0);
      drive_cycle(1'b0, v, d, rs);
      n_tests++; if (act_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, act_ready, exp_ready); end
      n_tests++; if (ifa.bus_o !== model_bus()) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %h expected %h", i, ifa.bus_o, model_bus()); end
      n_tests++; if (grant_a !== 2'(m_owner)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", i, grant_a, m_owner); end
      n_tests++; if (busy_a !== (m_onbus || m_gap > 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy_a, m_onbus || m_gap > 0); end
      n_tests++; if (sent_a !== m_sent) begin n_fail++; $display("FAIL rnd_sent[%0d]: got %0d expected %0d", i, sent_a, m_sent); end
      n_tests++; if (starve_a !== m_starve) begin n_fail++; $display("FAIL rnd_starve[%0d]: got %b expected %b", i, starve_a, m_starve); end
    end
  endtask

  initial begin
    ifa.req_valid = '0; ifa.req_data = '0; ifa.resend = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.resend = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_resend_backoff();
    test_starvation();
    test_reset_mid_backoff();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
